// File: rtl/ccff_prog_ctrl.sv
// Configuration-chain programming controller: fetches bitstream words,
// shifts them serially into the fabric chain and verifies the tail.
module ccff_prog_ctrl #(
  parameter int PRESET_CYC = 4,
  parameter int STALL_MAX  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] bit_len_i,
  input  logic [31:0] word_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  output logic        progclk_en_o,
  output logic        data_o,
  output logic        pReset_o,
  input  logic        ccff_tail_i,
  output logic        fpga_rst_o,
  output logic        fpga_clk_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int PW = (PRESET_CYC > 1) ? $clog2(PRESET_CYC) : 1;
  localparam int SW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESET,
    S_LOAD,
    S_SHIFT,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;

  state_e      state_q;
  logic [31:0] sreg_q;
  logic [15:0] rem_q;
  logic [5:0]  wcnt_q;
  logic        first_q;
  logic        firstw_q;
  logic [PW-1:0] pcnt_q;
  logic [SW-1:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      sreg_q   <= '0;
      rem_q    <= '0;
      wcnt_q   <= '0;
      first_q  <= 1'b0;
      firstw_q <= 1'b0;
      pcnt_q   <= '0;
      stall_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            rem_q    <= bit_len_i;
            pcnt_q   <= '0;
            firstw_q <= 1'b1;
            state_q  <= (bit_len_i == 16'd0) ? S_ERR : S_PRESET;
          end
        end
        S_PRESET: begin
          if (pcnt_q == PW'(PRESET_CYC - 1)) begin
            stall_q <= '0;
            state_q <= S_LOAD;
          end else begin
            pcnt_q <= pcnt_q + PW'(1);
          end
        end
        S_LOAD: begin
          if (word_valid_i) begin
            sreg_q   <= word_i;
            wcnt_q   <= (rem_q >= 16'd32) ? 6'd32 : rem_q[5:0];
            firstw_q <= 1'b0;
            if (firstw_q) first_q <= word_i[0];
            state_q  <= S_SHIFT;
          end else if (stall_q == SW'(STALL_MAX - 1)) begin
            state_q <= S_ERR;
          end else begin
            stall_q <= stall_q + SW'(1);
          end
        end
        S_SHIFT: begin
          sreg_q <= sreg_q >> 1;
          rem_q  <= rem_q - 16'd1;
          wcnt_q <= wcnt_q - 6'd1;
          if (rem_q == 16'd1) begin
            state_q <= S_CHECK;
          end else if (wcnt_q == 6'd1) begin
            stall_q <= '0;
            state_q <= S_LOAD;
          end
        end
        S_CHECK: begin
          state_q <= (ccff_tail_i == first_q) ? S_DONE : S_ERR;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register so reset is immediate
  assign word_ready_o  = (state_q == S_LOAD);
  assign progclk_en_o  = (state_q == S_SHIFT);
  assign data_o        = (state_q == S_SHIFT) & sreg_q[0];
  assign pReset_o      = (state_q == S_PRESET);
  assign busy_o        = (state_q == S_PRESET) | (state_q == S_LOAD) |
                         (state_q == S_SHIFT)  | (state_q == S_CHECK);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = (state_q == S_ERR);
  assign fpga_rst_o    = (state_q != S_DONE);
  assign fpga_clk_en_o = (state_q == S_DONE);

endmodule

// File: tb/tb_ccff_prog_ctrl.sv
// Scoreboard bench for ccff_prog_ctrl: random runs against a
// bit-queue / chain reference model.
module tb_ccff_prog_ctrl;

  localparam int PRESET_CYC = 4;
  localparam int STALL_MAX  = 1024;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] bit_len_i = '0;
  logic [31:0] word_i = '0;
  logic        word_valid_i = 1'b0;
  logic        ccff_tail_i = 1'b0;
  logic        word_ready_o, progclk_en_o, data_o, pReset_o;
  logic        fpga_rst_o, fpga_clk_en_o, busy_o, done_o, err_o;

  ccff_prog_ctrl #(
    .PRESET_CYC(PRESET_CYC),
    .STALL_MAX (STALL_MAX)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .bit_len_i    (bit_len_i),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .progclk_en_o (progclk_en_o),
    .data_o       (data_o),
    .pReset_o     (pReset_o),
    .ccff_tail_i  (ccff_tail_i),
    .fpga_rst_o   (fpga_rst_o),
    .fpga_clk_en_o(fpga_clk_en_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wq[$];
  logic [31:0] fixed_w[$];
  bit          exp_bits[$];
  int          exp_end[$];
  bit          chain[$];
  bit          tail_bad = 1'b0;
  bit          exp_starve = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_progclk"}, progclk_en_o, 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_preset"}, pReset_o, 0);
    chk({tag, "_ready"}, word_ready_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_fpga_rst"}, fpga_rst_o, 1);
    chk({tag, "_fpga_clk_en"}, fpga_clk_en_o, 0);
  endtask

  // Word source: offers queued words with random valid gaps
  initial begin
    bit hs;
    forever begin
      @(negedge clk_i);
      hs = word_valid_i & word_ready_o;
      @(posedge clk_i);
      if (hs && wq.size() > 0) void'(wq.pop_front());
      #1;
      word_valid_i = (wq.size() > 0) && ($urandom_range(3) != 0);
      word_i = (wq.size() > 0) ? wq[0] : $urandom;
    end
  end

  // Monitor: checks serial bits, preset length and run outcome; models chain
  initial begin
    int prun, rrun, e;
    logic [1:0] prev_end;
    prun = 0;
    rrun = 0;
    prev_end = 2'b00;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        prun = 0;
        rrun = 0;
        prev_end = 2'b00;
      end else begin
        if (progclk_en_o) begin
          if (exp_bits.size() == 0) chk("extra_shift", 1, 0);
          else chk("data_o", data_o, exp_bits.pop_front());
          chain.push_back(data_o);
        end else begin
          chk("data_idle", data_o, 0);
        end
        if (pReset_o) prun++;
        else begin
          if (prun != 0) chk("preset_len", prun, PRESET_CYC);
          prun = 0;
        end
        if ({done_o, err_o} != 2'b00 && {done_o, err_o} != prev_end) begin
          if (exp_end.size() == 0) chk("unexpected_end", 1, 0);
          else begin
            e = exp_end.pop_front();
            chk("end_state", {done_o, err_o}, (e == 1) ? 2'b10 : 2'b01);
            chk("end_fpga_rst", fpga_rst_o, e != 1);
            chk("end_fpga_clk_en", fpga_clk_en_o, e == 1);
            chk("shifts_left", exp_bits.size(), 0);
            if (exp_starve) chk("stall_len", rrun, STALL_MAX);
          end
        end
        prev_end = {done_o, err_o};
        if (word_ready_o) rrun++;
        else rrun = 0;
        ccff_tail_i = (chain.size() > 0) ? (chain[0] ^ tail_bad) : 1'b0;
      end
    end
  end

  task automatic prep(input int len, input bit bad, input int nsup);
    logic [31:0] words[$];
    logic [31:0] w;
    int nw, nsh;
    nw  = (len + 31) / 32;
    nsh = (len < 32 * nsup) ? len : 32 * nsup;
    for (int i = 0; i < nw; i++) begin
      words.push_back((i < fixed_w.size()) ? fixed_w[i] : $urandom);
      if (i < nsup) wq.push_back(words[i]);
    end
    for (int b = 0; b < nsh; b++) begin
      w = words[b / 32];
      exp_bits.push_back(w[b % 32]);
    end
    exp_end.push_back((bad || nsup < nw || len == 0) ? 2 : 1);
    exp_starve = (nsup < nw);
    tail_bad = bad;
    chain.delete();
  endtask

  task automatic pulse_start(input int len);
    bit was_done;
    was_done = done_o;
    start_i = 1'b1;
    bit_len_i = 16'(len);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    bit_len_i = 16'($urandom);
    if (was_done) begin
      chk("restart_fpga_rst", fpga_rst_o, 1);
      chk("restart_fpga_clk_en", fpga_clk_en_o, 0);
      chk("restart_preset", pReset_o, len != 0);
    end
    if (len == 0) chk("zero_len_err", err_o, 1);
  endtask

  task automatic run(input int len, input bit bad, input int nsup,
                     input bit poke);
    bit poked, ended;
    prep(len, bad, nsup);
    pulse_start(len);
    poked = 1'b0;
    ended = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (done_o | err_o) begin
        ended = 1'b1;
        break;
      end
      if (poke && progclk_en_o && !poked) begin
        start_i = 1'b1;
        bit_len_i = 16'($urandom_range(1, 200));
        poked = 1'b1;
      end
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
    end
    if (!ended) chk("run_timeout", 1, 0);
    @(posedge clk_i);
    #1;
    chk("end_seen", exp_end.size(), 0);
    chk("words_used", wq.size(), 0);
  endtask

  task automatic reset_mid_shift();
    int n;
    bit hit;
    prep(40, 1'b0, 2);
    pulse_start(40);
    n = 0;
    hit = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (progclk_en_o) n++;
      if (n == 10) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    if (!hit) chk("mid_shift_timeout", 1, 0);
    #2;
    rst_i = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    wq.delete();
    exp_bits.delete();
    exp_end.delete();
    chain.delete();
    exp_starve = 1'b0;
    repeat (2) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    chk("post_rst_idle_busy", busy_o, 0);
    chk("post_rst_idle_preset", pReset_o, 0);
    run(40, 1'b0, 2, 1'b0);
  endtask

  initial begin
    #1;
    rst_i = 1'b0;
    #2;
    check_reset_vals("por");
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    chk("idle_after_rst_busy", busy_o, 0);
    chk("idle_after_rst_fpga_rst", fpga_rst_o, 1);

    fixed_w.push_back(32'h0000_0017);
    fixed_w.push_back(32'h0000_00A5);
    run(40, 1'b0, 2, 1'b0);
    run(0, 1'b0, 0, 1'b0);
    run(40, 1'b1, 2, 1'b0);
    fixed_w.delete();

    run(64, 1'b0, 1, 1'b0);
    run(32, 1'b0, 1, 1'b0);
    run(33, 1'b0, 2, 1'b0);
    reset_mid_shift();
    run(40, 1'b0, 2, 1'b1);
    run(40, 1'b0, 2, 1'b0);

    for (int i = 0; i < 10; i++) begin
      int len;
      len = $urandom_range(1, 100);
      run(len, ($urandom_range(3) == 0), (len + 31) / 32, $urandom_range(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
